// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction field positions, ALU classes and the
// EX control bundle whose all-zero value is the bubble.
package pipe_pkg;

  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_IMM   = 2'b11
  } aluOp_e;

  // Order here is the bundle order seen by EX/MEM/WB.
  typedef struct packed {
    logic   regWrite;
    logic   memtoReg;
    logic   memRead;
    logic   memWrite;
    logic   aluSrc;
    logic   regDst;
    aluOp_e aluOp;
  } ctrl_t;

  localparam int    CTRL_W = $bits(ctrl_t);
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: ID-side operands and control in, EX-side registered slot out.
// master = upstream ID logic, slave = the pipeline register.
interface id_ex_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) ();
    logic              stall;
    logic              flush;
    logic [31:0]       instru;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              RegWrite;
    logic              MemtoReg;
    logic              MemRead;
    logic              MemWrite;
    logic              ALUSrc;
    logic              RegDst;
    logic [1:0]        ALUOp;
    logic              wb_RegWrite;
    logic [REG_AW-1:0] wb_WriteReg;
    logic [DATA_W-1:0] wb_WriteData;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc_plus4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [5:0]        ex_funct;
    logic              ex_RegWrite;
    logic              ex_MemtoReg;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_ALUSrc;
    logic              ex_RegDst;
    logic [1:0]        ex_ALUOp;
    logic              load_use_hazard;

    modport master (
        output stall, flush, instru, pc_plus4, ReadData1, ReadData2,
               RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp,
               wb_RegWrite, wb_WriteReg, wb_WriteData,
        input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_funct,
               ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc,
               ex_RegDst, ex_ALUOp, load_use_hazard
    );

    modport slave (
        input  stall, flush, instru, pc_plus4, ReadData1, ReadData2,
               RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp,
               wb_RegWrite, wb_WriteReg, wb_WriteData,
        output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_funct,
               ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc,
               ex_RegDst, ex_ALUOp, load_use_hazard
    );
endinterface

// File: rtl/id_wb_bypass.sv
// WB-to-ID bypass: replaces register-file read data with the same-cycle WB write
// when it targets the register being read (register 0 is never bypassed).
module id_wb_bypass #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              wb_RegWrite,
    input  logic [REG_AW-1:0] wb_WriteReg,
    input  logic [DATA_W-1:0] wb_WriteData,
    input  logic [REG_AW-1:0] rsIdx,
    input  logic [REG_AW-1:0] rtIdx,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] rsData,
    output logic [DATA_W-1:0] rtData
);
    logic wbLive;

    assign wbLive = wb_RegWrite && (wb_WriteReg != '0);
    assign rsData = (wbLive && wb_WriteReg == rsIdx) ? wb_WriteData : ReadData1;
    assign rtData = (wbLive && wb_WriteReg == rtIdx) ? wb_WriteData : ReadData2;
endmodule

// File: rtl/id_ex_reg.sv
// ID->EX pipeline register with stall/flush and a combinational load-use request.
// Define ID_EX_WB_BYPASS_EN to bypass same-cycle WB writes into the captured operands.
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         rst,
    id_ex_reg_if.slave  bus
);
    function automatic logic signed [DATA_W-1:0] signExt(input logic [15:0] imm16);
        return DATA_W'($signed(imm16));
    endfunction

    ctrl_t                    idCtrl;
    logic [DATA_W-1:0]        rsData;
    logic [DATA_W-1:0]        rtData;
    logic [REG_AW-1:0]        idRs;
    logic [REG_AW-1:0]        idRt;

    logic                     exValid;
    ctrl_t                    exCtrl;
    logic [DATA_W-1:0]        exPc;
    logic [DATA_W-1:0]        exRsData;
    logic [DATA_W-1:0]        exRtData;
    logic signed [DATA_W-1:0] exImm;
    logic [REG_AW-1:0]        exRs;
    logic [REG_AW-1:0]        exRt;
    logic [REG_AW-1:0]        exRd;
    logic [5:0]               exFunct;

    assign idRs   = bus.instru[RS_HI:RS_LO];
    assign idRt   = bus.instru[RT_HI:RT_LO];
    assign idCtrl = '{regWrite: bus.RegWrite, memtoReg: bus.MemtoReg,
                      memRead:  bus.MemRead,  memWrite: bus.MemWrite,
                      aluSrc:   bus.ALUSrc,   regDst:   bus.RegDst,
                      aluOp:    aluOp_e'(bus.ALUOp)};

`ifdef ID_EX_WB_BYPASS_EN
    id_wb_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) uBypass (
        .wb_RegWrite (bus.wb_RegWrite),
        .wb_WriteReg (bus.wb_WriteReg),
        .wb_WriteData(bus.wb_WriteData),
        .rsIdx       (idRs),
        .rtIdx       (idRt),
        .ReadData1   (bus.ReadData1),
        .ReadData2   (bus.ReadData2),
        .rsData      (rsData),
        .rtData      (rtData)
    );
`else
    assign rsData = bus.ReadData1;
    assign rtData = bus.ReadData2;
`endif

    // ID -> EX stage boundary: reset and flush both leave a bubble that cannot write anything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exValid  <= 1'b0;
            exCtrl   <= BUBBLE;
            exPc     <= '0;
            exRsData <= '0;
            exRtData <= '0;
            exImm    <= '0;
            exRs     <= '0;
            exRt     <= '0;
            exRd     <= '0;
            exFunct  <= '0;
        end else if (bus.flush) begin
            exValid  <= 1'b0;
            exCtrl   <= BUBBLE;
            exPc     <= '0;
            exRsData <= '0;
            exRtData <= '0;
            exImm    <= '0;
            exRs     <= '0;
            exRt     <= '0;
            exRd     <= '0;
            exFunct  <= '0;
        end else if (!bus.stall) begin
            exValid  <= 1'b1;
            exCtrl   <= idCtrl;
            exPc     <= bus.pc_plus4;
            exRsData <= rsData;
            exRtData <= rtData;
            exImm    <= signExt(bus.instru[IMM_HI:IMM_LO]);
            exRs     <= idRs;
            exRt     <= idRt;
            exRd     <= bus.instru[RD_HI:RD_LO];
            exFunct  <= bus.instru[FUNCT_HI:FUNCT_LO];
        end
    end

    assign bus.ex_valid    = exValid;
    assign bus.ex_pc_plus4 = exPc;
    assign bus.ex_rs_data  = exRsData;
    assign bus.ex_rt_data  = exRtData;
    assign bus.ex_imm      = exImm;
    assign bus.ex_rs       = exRs;
    assign bus.ex_rt       = exRt;
    assign bus.ex_rd       = exRd;
    assign bus.ex_funct    = exFunct;
    assign bus.ex_RegWrite = exCtrl.regWrite;
    assign bus.ex_MemtoReg = exCtrl.memtoReg;
    assign bus.ex_MemRead  = exCtrl.memRead;
    assign bus.ex_MemWrite = exCtrl.memWrite;
    assign bus.ex_ALUSrc   = exCtrl.aluSrc;
    assign bus.ex_RegDst   = exCtrl.regDst;
    assign bus.ex_ALUOp    = exCtrl.aluOp;

    // rt is compared against both ID source fields even for I-type: a false stall is harmless.
    assign bus.load_use_hazard = exValid & exCtrl.memRead & (exRt != '0) &
                                 ((exRt == idRs) | (exRt == idRt));
endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed cases plus a randomized ID stream
// compared against a one-slot behavioural model of the EX register.
module tb_id_ex_reg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct {
        bit        valid;
        bit [31:0] pc, rsd, rtd, imm;
        int        rs, rt, rd, funct;
        bit        rw, m2r, mr, mw, as, rdst;
        int        aluop;
    } slot_t;

    logic  clk = 1'b0;
    logic  rst;
    slot_t exp;
    int    checkCnt = 0;
    int    passCnt  = 0;

    id_ex_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();
    id_ex_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checkCnt++;
        if (got === want) passCnt++;
        else $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    function automatic int fieldRs(input bit [31:0] ins);
        return int'((ins >> 21) & 32'h1F);
    endfunction
    function automatic int fieldRt(input bit [31:0] ins);
        return int'((ins >> 16) & 32'h1F);
    endfunction

    // Reference: what EX should hold after a normal load of the current ID inputs.
    function automatic slot_t loadSlot();
        slot_t  s;
        bit [31:0] ins;
        int     wbReg;
        ins     = bus.instru;
        s.valid = 1;
        s.pc    = bus.pc_plus4;
        s.rs    = fieldRs(ins);
        s.rt    = fieldRt(ins);
        s.rd    = int'((ins >> 11) & 32'h1F);
        s.funct = int'(ins & 32'h3F);
        s.imm   = ins & 32'hFFFF;
        if (s.imm >= 32'h8000) s.imm = s.imm + 32'hFFFF0000;
        s.rsd   = bus.ReadData1;
        s.rtd   = bus.ReadData2;
`ifdef ID_EX_WB_BYPASS_EN
        wbReg = int'(bus.wb_WriteReg);
        if (bus.wb_RegWrite && wbReg != 0 && wbReg == s.rs) s.rsd = bus.wb_WriteData;
        if (bus.wb_RegWrite && wbReg != 0 && wbReg == s.rt) s.rtd = bus.wb_WriteData;
`else
        wbReg = 0;
`endif
        s.rw    = bus.RegWrite;
        s.m2r   = bus.MemtoReg;
        s.mr    = bus.MemRead;
        s.mw    = bus.MemWrite;
        s.as    = bus.ALUSrc;
        s.rdst  = bus.RegDst;
        s.aluop = int'(bus.ALUOp);
        return s;
    endfunction

    function automatic bit expHazard();
        bit [31:0] ins;
        ins = bus.instru;
        return exp.valid && exp.mr && exp.rt != 0 &&
               (exp.rt == fieldRs(ins) || exp.rt == fieldRt(ins));
    endfunction

    task automatic compareSlot(input string tag);
        check({tag, ".valid"}, bus.ex_valid,    exp.valid);
        check({tag, ".pc"},    bus.ex_pc_plus4, exp.pc);
        check({tag, ".rsd"},   bus.ex_rs_data,  exp.rsd);
        check({tag, ".rtd"},   bus.ex_rt_data,  exp.rtd);
        check({tag, ".imm"},   bus.ex_imm,      exp.imm);
        check({tag, ".rs"},    bus.ex_rs,       exp.rs);
        check({tag, ".rt"},    bus.ex_rt,       exp.rt);
        check({tag, ".rd"},    bus.ex_rd,       exp.rd);
        check({tag, ".funct"}, bus.ex_funct,    exp.funct);
        check({tag, ".ctrl"},
              {bus.ex_RegWrite, bus.ex_MemtoReg, bus.ex_MemRead, bus.ex_MemWrite,
               bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_ALUOp},
              {exp.rw, exp.m2r, exp.mr, exp.mw, exp.as, exp.rdst, 2'(exp.aluop)});
    endtask

    // One clock: update the model from the inputs present at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (bus.flush) exp = '{default: 0};
        else if (!bus.stall) exp = loadSlot();
        #1;
        compareSlot(tag);
    endtask

    task automatic setIn(input logic [31:0] ins, input logic memRead, input logic st, input logic fl);
        bus.instru      = ins;
        bus.pc_plus4    = $urandom;
        bus.ReadData1   = $urandom;
        bus.ReadData2   = $urandom;
        bus.RegWrite    = 1'($urandom);
        bus.MemtoReg    = 1'($urandom);
        bus.MemRead     = memRead;
        bus.MemWrite    = 1'($urandom);
        bus.ALUSrc      = 1'($urandom);
        bus.RegDst      = 1'($urandom);
        bus.ALUOp       = 2'($urandom);
        bus.wb_RegWrite = 1'b0;
        bus.wb_WriteReg = '0;
        bus.wb_WriteData = '0;
        bus.stall       = st;
        bus.flush       = fl;
    endtask

    task automatic randIn();
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(0, 3) == 0) ins = (ins & ~(32'h1F << 21)) | (32'(exp.rt) << 21);
        setIn(ins, 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        bus.wb_RegWrite  = 1'($urandom);
        bus.wb_WriteReg  = ($urandom_range(0, 1) == 0) ? ins[25:21] : 5'($urandom);
        bus.wb_WriteData = $urandom;
    endtask

    initial begin
        logic [31:0] expRs;
        rst = 1'b1;
        exp = '{default: 0};
        setIn(32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        compareSlot("reset0");

        // Asynchronous reset mid-cycle, then a clean load on release.
        #10 rst = 1'b0;
        randIn();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        step("preRst");
        #2 rst = 1'b1;
        exp = '{default: 0};
        #1 compareSlot("asyncRst");
        #2 rst = 1'b0;
        setIn(32'h00221820, 1'b0, 1'b0, 1'b0);
        step("addLoad");
        check("add.rs", bus.ex_rs, 1);
        check("add.rt", bus.ex_rt, 2);
        check("add.rd", bus.ex_rd, 3);
        check("add.valid", bus.ex_valid, 1);

        // Sign extension boundaries.
        setIn(32'h20228004, 1'b0, 1'b0, 1'b0);
        step("sx8004");
        check("imm8004", bus.ex_imm, 32'hFFFF8004);
        setIn(32'h20227FFF, 1'b0, 1'b0, 1'b0);
        step("sx7fff");
        check("imm7fff", bus.ex_imm, 32'h00007FFF);

        // Stall holds for three cycles while inputs churn; stall+flush gives a bubble.
        for (int i = 0; i < 3; i++) begin
            setIn($urandom, 1'($urandom), 1'b1, 1'b0);
            step("stall");
            check("stall.imm", bus.ex_imm, 32'h00007FFF);
        end
        setIn($urandom, 1'b1, 1'b1, 1'b1);
        step("stallFlush");
        check("flush.valid", bus.ex_valid, 0);

        // Load-use detection.
        setIn({6'h23, 5'd1, 5'd5, 16'd0}, 1'b1, 1'b0, 1'b0);
        step("lw5");
        setIn({6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20}, 1'b0, 1'b0, 1'b0);
        #1;
        check("hazRs5", bus.load_use_hazard, 1);
        check("hazRs5Model", bus.load_use_hazard, expHazard());
        setIn({6'h23, 5'd1, 5'd0, 16'd0}, 1'b1, 1'b0, 1'b0);
        step("lw0");
        setIn({6'h00, 5'd0, 5'd0, 5'd6, 5'd0, 6'h20}, 1'b0, 1'b0, 1'b0);
        #1 check("hazRt0", bus.load_use_hazard, 0);
        setIn({6'h23, 5'd1, 5'd5, 16'd0}, 1'b1, 1'b0, 1'b1);
        step("lwFlushed");
        setIn({6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20}, 1'b0, 1'b0, 1'b0);
        #1 check("hazInvalid", bus.load_use_hazard, 0);

        // WB bypass into the rs operand.
`ifdef ID_EX_WB_BYPASS_EN
        expRs = 32'hDEADBEEF;
`else
        expRs = 32'h0;
`endif
        setIn({6'h00, 5'd7, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b0, 1'b0, 1'b0);
        bus.ReadData1 = '0;
        bus.wb_RegWrite = 1'b1;
        bus.wb_WriteReg = 5'd7;
        bus.wb_WriteData = 32'hDEADBEEF;
        step("byp7");
        check("byp7.rsd", bus.ex_rs_data, expRs);
        setIn({6'h00, 5'd7, 5'd2, 5'd3, 5'd0, 6'h20}, 1'b0, 1'b0, 1'b0);
        bus.ReadData1 = '0;
        bus.wb_RegWrite = 1'b1;
        bus.wb_WriteReg = 5'd0;
        bus.wb_WriteData = 32'hDEADBEEF;
        step("byp0");
        check("byp0.rsd", bus.ex_rs_data, 0);

        // Randomized stream against the model, hazard checked after each new ID input.
        for (int i = 0; i < 400; i++) begin
            randIn();
            #1 check("rndHaz", bus.load_use_hazard, expHazard());
            step("rnd");
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
